hex_display_ctrl: RTL and testbench
===================================

// Module: hex_display_ctrl
// PURPOSE
//  Sequential binary-to-decimal display scheduler for the board's HEX bank.
//  - Takes a binary parameter value (delay time, gain, etc.) from the effects control path.
//  - Converts it with a double-dabble loop, one bit per cycle.
//  - Blanks leading zeros and marks overflow.
//  - Drives one 4-bit digit code per 7-seg decoder instance: 0-9 = digit, 10 = off, 15 = dash.
// PARAMETERS
//  NUM_DIGITS  6   digits driven; digit 0 = rightmost
//  VAL_W       20  input value width; must satisfy 2**VAL_W > 10**NUM_DIGITS - 1
// PORTS
//  clk            in   1             system clock; all state on rising edge
//  rst_n          in   1             reset, asynchronous, active-low
//  value_i        in   VAL_W         value to display
//  value_valid_i  in   1             1-cycle strobe, value_i sampled when high
//  digits_o       out  4*NUM_DIGITS  digit codes, digit k at [4k+3:4k], registered
//  busy_o         out  1             high while state != IDLE
//  upd_done_o     out  1             1-cycle pulse, coincident with a digits_o update
//  ovf_o          out  1             registered with digits_o; value did not fit
// BEHAVIOUR
//  Reset values:
//  - digits_o = all DIG_OFF; busy_o, upd_done_o and ovf_o = 0.
//  - pending slot empty; state = IDLE; BCD and shift registers = 0.
//  FSM states: IDLE, CONVERT, COMMIT.
//  - IDLE: if the pending slot is full, take the value from it and clear the slot.
//    Otherwise, if value_valid_i is high, take value_i.
//    - Value taken and in range (<= MAX) -> load shift register, clear BCD, go to CONVERT.
//    - Value taken and out of range -> set ovf flag, go directly to COMMIT.
//  - CONVERT: exactly VAL_W cycles.
//    - Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
//    - After the VAL_W-th shift, go to COMMIT.
//  - COMMIT: one cycle; go to IDLE.
//    - Load digits_o with leading-zero blanking: nibbles above the most significant
//      nonzero nibble become DIG_OFF. Digit 0 is never blanked, so value 0 shows "0".
//    - If ovf, every digit = DIG_DASH.
//    - Assert upd_done_o and update ovf_o.
//  MAX = 10**NUM_DIGITS - 1.
//  Latency, counted from the accepting edge:
//  - in range: digits_o changes VAL_W+1 cycles later (21 at defaults).
//  - overflow: 1 cycle later.
//  Pending buffer (one deep):
//  - value_valid_i while busy_o is high writes the pending slot.
//  - A newer strobe overwrites an older one; only the last value is shown.
//  - One IDLE cycle always separates back-to-back conversions.
//  - value_valid_i in IDLE while the slot is full: the strobed value overwrites the
//    slot, and that strobed value is the one converted next.
//  Stable output: digits_o never shows partial results; it changes only on the COMMIT edge.
//  Reset asserted mid-CONVERT or mid-COMMIT:
//  - all registers return to reset values immediately; the pending value is discarded.
// CONFIGURATION
//  HEXDISP_SIGNED_EN defined:
//  - value_i is two's complement; the block converts its magnitude.
//  - Negative values: a DIG_DASH goes in the first blanked position left of the most
//    significant digit.
//  - Negative magnitude > 10**(NUM_DIGITS-1) - 1 -> all dashes, ovf_o = 1.
//  - The most-negative input is handled as a VAL_W-bit unsigned magnitude.
//  HEXDISP_SIGNED_EN undefined: value_i is unsigned and no sign logic is present.
// STRUCTURE
//  Package hexdisp_pkg:
//  - DIG_OFF = 4'd10, DIG_DASH = 4'd15.
//  - typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} hexdisp_state_t.
//  - function blank_lz(), shared with the bench model.
//  Sub-module bin2bcd_step (combinational):
//  - one add-3 / shift iteration over NUM_DIGITS nibbles plus the binary register.
//  - instantiated once in the CONVERT datapath.
//  Iteration counter width: $clog2(VAL_W+1).
// TESTING
//  1 Reset: rst_n low -> digits_o = 24'hAAAAAA, busy_o = 0, ovf_o = 0.
//  2 1234 strobed in IDLE -> busy_o high 21 cycles; digits_o = 24'hAA1234 with upd_done_o pulse.
//  3 0 -> digits_o = 24'hAAAAA0; 999999 -> 24'h999999, ovf_o = 0.
//  4 1000000 -> 1 cycle later digits_o = 24'hFFFFFF, ovf_o = 1.
//    A following 7 -> 24'hAAAAA7, ovf_o = 0.
//  5 Strobe 5, then 77 and 999999 while busy:
//    - displays 24'hAAAAA5, then 24'h999999; 77 never shown.
//    - exactly two upd_done_o pulses.
//  6 Reset pulse 10 cycles into converting 555 -> digits_o = 24'hAAAAAA, no upd_done_o.
//    SIGNED_EN build: -42 -> 24'hAAAF42; -100000 -> 24'hFFFFFF, ovf_o = 1.

Source files
------------

// File: rtl/hexdisp_pkg.sv
// ============================================================================
// Module      : hexdisp_pkg
// Description : Shared digit codes, FSM state type and leading-zero helper
//               for the HEX display scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hexdisp_pkg;

    localparam logic [3:0] DIG_OFF  = 4'd10;
    localparam logic [3:0] DIG_DASH = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } hexdisp_state_t;

    // A zero nibble with no nonzero nibble above it is blanked, except digit 0.
    function automatic logic [3:0] blank_lz(
        input logic [3:0] nib,
        input logic       higher_nz,
        input logic       is_lsd
    );
        return ((nib == 4'd0) && !higher_nz && !is_lsd) ? DIG_OFF : nib;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_step.sv
// ============================================================================
// Module      : bin2bcd_step
// Description : One combinational double-dabble iteration (add-3, shift-left).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_step #(
    parameter int NUM_DIGITS = 6,
    parameter int VAL_W      = 20
) (
    input  logic [4*NUM_DIGITS-1:0] bcd_i,
    input  logic [VAL_W-1:0]        bin_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic [VAL_W-1:0]        bin_o,
    output logic                    carry_o
);

    logic [4*NUM_DIGITS-1:0] w_adj;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
        assign w_adj[4*k +: 4] = (bcd_i[4*k +: 4] >= 4'd5) ? (bcd_i[4*k +: 4] + 4'd3)
                                                          : bcd_i[4*k +: 4];
    end

    // carry_o is the BCD bit pushed off the top; nonzero means the result no longer fits.
    assign {carry_o, bcd_o, bin_o} = {w_adj, bin_i, 1'b0};

endmodule

`default_nettype wire

// File: rtl/hex_display_ctrl.sv
// ============================================================================
// Module      : hex_display_ctrl
// Description : Sequential binary-to-decimal scheduler for the HEX bank with
//               leading-zero blanking, overflow dashes and a one-deep pending
//               slot. Optional signed display via HEXDISP_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_display_ctrl
    import hexdisp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int VAL_W      = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [VAL_W-1:0]        value_i,
    input  logic                    value_valid_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic                    busy_o,
    output logic                    upd_done_o,
    output logic                    ovf_o
);

    localparam int                DW       = 4 * NUM_DIGITS;
    localparam int                CNT_W    = $clog2(VAL_W + 1);
    localparam logic [VAL_W-1:0]  MAX_VAL  = VAL_W'(10**NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(VAL_W - 1);
`ifdef HEXDISP_SIGNED_EN
    localparam logic [VAL_W-1:0]  MAX_NEG  = VAL_W'(10**(NUM_DIGITS - 1) - 1);
`endif

    hexdisp_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     bcd_q, bcd_d;
    logic [VAL_W-1:0]  bin_q, bin_d;
    logic              ovf_q, ovf_d;
    logic              pend_full_q, pend_full_d;
    logic [VAL_W-1:0]  pend_val_q, pend_val_d;
    logic [DW-1:0]     digits_q, digits_d;
    logic              ovf_out_q, ovf_out_d;
    logic              upd_q, upd_d;
`ifdef HEXDISP_SIGNED_EN
    logic              neg_q, neg_d;
`endif

    logic [VAL_W-1:0]  w_take_val, w_mag;
    logic              w_neg, w_in_range;
    logic [DW-1:0]     w_step_bcd, w_blank, w_fmt;
    logic [VAL_W-1:0]  w_step_bin;
    logic              w_step_carry;

    bin2bcd_step #(
        .NUM_DIGITS (NUM_DIGITS),
        .VAL_W      (VAL_W)
    ) u_step (
        .bcd_i   (bcd_q),
        .bin_i   (bin_q),
        .bcd_o   (w_step_bcd),
        .bin_o   (w_step_bin),
        .carry_o (w_step_carry)
    );

    // A fresh strobe always wins over the pending slot.
    always_comb begin
        w_take_val = value_valid_i ? value_i : pend_val_q;
        w_neg      = 1'b0;
        w_mag      = w_take_val;
        w_in_range = (w_take_val <= MAX_VAL);
`ifdef HEXDISP_SIGNED_EN
        w_neg      = w_take_val[VAL_W-1];
        w_mag      = w_neg ? (~w_take_val + 1'b1) : w_take_val;
        w_in_range = w_neg ? (w_mag <= MAX_NEG) : (w_mag <= MAX_VAL);
`endif
    end

    always_comb begin
        logic nz;
        nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_blank[4*k +: 4] = blank_lz(bcd_q[4*k +: 4], nz, (k == 0));
            nz = nz | (bcd_q[4*k +: 4] != 4'd0);
        end
        w_fmt = w_blank;
`ifdef HEXDISP_SIGNED_EN
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (neg_q && (w_blank[4*k +: 4] == DIG_OFF) && (w_blank[4*(k-1) +: 4] != DIG_OFF))
                w_fmt[4*k +: 4] = DIG_DASH;
        end
`endif
        if (ovf_q)
            w_fmt = {NUM_DIGITS{DIG_DASH}};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        ovf_d       = ovf_q;
        pend_full_d = pend_full_q;
        pend_val_d  = pend_val_q;
        digits_d    = digits_q;
        ovf_out_d   = ovf_out_q;
        upd_d       = 1'b0;
`ifdef HEXDISP_SIGNED_EN
        neg_d       = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (value_valid_i || pend_full_q) begin
                    pend_full_d = 1'b0;
                    cnt_d       = '0;
                    bcd_d       = '0;
                    bin_d       = w_in_range ? w_mag : '0;
                    ovf_d       = !w_in_range;
                    state_d     = w_in_range ? CONVERT : COMMIT;
`ifdef HEXDISP_SIGNED_EN
                    neg_d       = w_neg;
`endif
                end
            end
            CONVERT: begin
                bcd_d = w_step_bcd;
                bin_d = w_step_bin;
                cnt_d = cnt_q + 1'b1;
                if (w_step_carry)
                    ovf_d = 1'b1;
                if (cnt_q == LAST_CNT)
                    state_d = COMMIT;
            end
            COMMIT: begin
                digits_d  = w_fmt;
                ovf_out_d = ovf_q;
                upd_d     = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && value_valid_i) begin
            pend_full_d = 1'b1;
            pend_val_d  = value_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bcd_q       <= '0;
            bin_q       <= '0;
            ovf_q       <= 1'b0;
            pend_full_q <= 1'b0;
            pend_val_q  <= '0;
            digits_q    <= {NUM_DIGITS{DIG_OFF}};
            ovf_out_q   <= 1'b0;
            upd_q       <= 1'b0;
`ifdef HEXDISP_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            ovf_q       <= ovf_d;
            pend_full_q <= pend_full_d;
            pend_val_q  <= pend_val_d;
            digits_q    <= digits_d;
            ovf_out_q   <= ovf_out_d;
            upd_q       <= upd_d;
`ifdef HEXDISP_SIGNED_EN
            neg_q       <= neg_d;
`endif
        end
    end

    assign digits_o   = digits_q;
    assign busy_o     = (state_q != IDLE);
    assign upd_done_o = upd_q;
    assign ovf_o      = ovf_out_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
// ============================================================================
// Module      : tb_hex_display_ctrl
// Description : Scoreboard bench for hex_display_ctrl with a decimal reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_display_ctrl;

    localparam int ND = 6;
    localparam int VW = 20;
    localparam int DW = 4 * ND;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] value_i = '0;
    logic          value_valid_i = 1'b0;
    logic [DW-1:0] digits_o;
    logic          busy_o, upd_done_o, ovf_o;

    hex_display_ctrl #(.NUM_DIGITS(ND), .VAL_W(VW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .value_i       (value_i),
        .value_valid_i (value_valid_i),
        .digits_o      (digits_o),
        .busy_o        (busy_o),
        .upd_done_o    (upd_done_o),
        .ovf_o         (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ovf;
        logic [DW-1:0] dig;
        int unsigned   at;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int          m_busy = 0;
    bit          m_pfull = 0;
    logic [VW-1:0] m_pval = '0;
    logic [DW-1:0] prev_dig;

    // Decimal rendering of a value straight from the display rules.
    function automatic logic [DW:0] ref_disp(input logic [VW-1:0] v);
        logic [DW-1:0] d;
        longint mag, lim, p;
        bit neg;
        int nsig;
        neg = 0;
        mag = longint'(v);
`ifdef HEXDISP_SIGNED_EN
        if (v[VW-1]) begin
            neg = 1;
            mag = (longint'(1) << VW) - longint'(v);
        end
`endif
        lim = neg ? (longint'(10)**(ND-1) - 1) : (longint'(10)**ND - 1);
        if (mag > lim)
            return {1'b1, {ND{4'hF}}};
        d = {ND{4'hA}};
        p = 1;
        nsig = 0;
        for (int k = 0; k < ND; k++) begin
            if (k == 0 || mag >= p) begin
                d[4*k +: 4] = 4'((mag / p) % 10);
                nsig = k + 1;
            end
            p = p * 10;
        end
        if (neg)
            d[4*nsig +: 4] = 4'hF;
        return {1'b0, d};
    endfunction

    task automatic accept(input logic [VW-1:0] v);
        logic [DW:0] r;
        exp_t e;
        int lat;
        r   = ref_disp(v);
        lat = r[DW] ? 1 : VW + 1;
        e.ovf = r[DW];
        e.dig = r[DW-1:0];
        e.at  = cyc + lat;
        sb.push_back(e);
        m_busy = lat;
    endtask

    // Abstract occupancy model: busy for the conversion latency, last strobe while busy is kept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 0;
            m_pfull = 0;
            sb.delete();
        end else begin
            cyc++;
            if (m_busy == 0) begin
                if (value_valid_i)
                    accept(value_i);
                else if (m_pfull)
                    accept(m_pval);
                m_pfull = 0;
            end else begin
                if (value_valid_i) begin
                    m_pfull = 1;
                    m_pval  = value_i;
                end
                m_busy--;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_dig = digits_o;
        end else begin
            n_cmp++;
            if (busy_o !== (m_busy != 0)) begin
                n_err++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, (m_busy != 0));
            end
            if (upd_done_o) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_upd cyc=%0d digits=%h", cyc, digits_o);
                end else begin
                    e = sb.pop_front();
                    if (digits_o !== e.dig || ovf_o !== e.ovf) begin
                        n_err++;
                        $display("FAIL display got=%h/ovf%b exp=%h/ovf%b", digits_o, ovf_o, e.dig, e.ovf);
                    end
                    n_cmp++;
                    if (cyc != e.at) begin
                        n_err++;
                        $display("FAIL upd_time got=%0d exp=%0d", cyc, e.at);
                    end
                end
            end else begin
                n_cmp++;
                if (digits_o !== prev_dig) begin
                    n_err++;
                    $display("FAIL digits_stable got=%h exp=%h", digits_o, prev_dig);
                end
            end
            prev_dig = digits_o;
        end
    end

    task automatic check_reset_state(input string tag);
        n_cmp++;
        if (digits_o !== {ND{4'hA}} || busy_o !== 1'b0 || ovf_o !== 1'b0 || upd_done_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s got=%h busy%b ovf%b upd%b exp=aaaaaa busy0 ovf0 upd0",
                     tag, digits_o, busy_o, ovf_o, upd_done_o);
        end
    endtask

    task automatic strobe(input logic [VW-1:0] v);
        @(negedge clk);
        value_valid_i = 1'b1;
        value_i       = v;
        @(negedge clk);
        value_valid_i = 1'b0;
    endtask

    task automatic wait_quiet();
        int i;
        i = 0;
        while (i < 300 && !(m_busy == 0 && !m_pfull && sb.size() == 0)) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (!(m_busy == 0 && !m_pfull && sb.size() == 0)) begin
            n_err++;
            $display("FAIL quiet_timeout pending=%0d exp=0", sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        logic [VW-1:0] rv;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        strobe(20'd1234);    wait_quiet();
        strobe(20'd0);       wait_quiet();
        strobe(20'd999999);  wait_quiet();
        strobe(20'd1000000); wait_quiet();
        strobe(20'd7);       wait_quiet();

        strobe(20'd5);
        repeat (4) @(negedge clk);
        strobe(20'd77);
        repeat (3) @(negedge clk);
        strobe(20'd999999);
        wait_quiet();

`ifdef HEXDISP_SIGNED_EN
        strobe(-20'sd42);     wait_quiet();
        strobe(-20'sd100000); wait_quiet();
        strobe(-20'sd99999);  wait_quiet();
        strobe(20'h80000);    wait_quiet();
`endif

        strobe(20'd555);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("reset_mid_convert");
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (digits_o !== {ND{4'hA}}) begin
            n_err++;
            $display("FAIL post_reset_digits got=%h exp=aaaaaa", digits_o);
        end

        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 4))
                0:       rv = VW'($urandom_range(0, 99));
                1:       rv = VW'($urandom_range(0, 999999));
                2:       rv = VW'($urandom_range(999990, 1048575));
                3:       rv = VW'($urandom_range(99990, 100010));
                default: rv = VW'($urandom);
            endcase
            strobe(rv);
            repeat ($urandom_range(0, 25)) @(negedge clk);
        end
        wait_quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
